// File: rtl/lamp_pkg.sv
// Shared types and constants for the traffic lamp controller.
//   state_t : 2-bit phase encoding (RED=0, GREEN=1, YELLOW=2, FLASH=3)
//   RGY_*   : one-hot lamp codes, bit order [0:2] = R,G,Y
package lamp_pkg;

  typedef enum logic [1:0] {
    RED    = 2'd0,
    GREEN  = 2'd1,
    YELLOW = 2'd2,
    FLASH  = 2'd3
  } state_t;

  localparam logic [0:2] RGY_RED    = 3'b100;
  localparam logic [0:2] RGY_GREEN  = 3'b010;
  localparam logic [0:2] RGY_YELLOW = 3'b001;
  localparam logic [0:2] RGY_DARK   = 3'b000;

endpackage

// File: rtl/traffic_lamp_ctrl_if.sv
// Control/status bundle between a junction controller and one lamp head.
//   enable, flash, ped_req : controller -> lamp
//   light, ped_ack, phase  : lamp -> controller
interface traffic_lamp_ctrl_if;

  logic       enable;
  logic       flash;
  logic       ped_req;
  logic [0:2] light;
  logic       ped_ack;
  logic [1:0] phase;

  modport master (
    output enable, flash, ped_req,
    input  light, ped_ack, phase
  );

  modport slave (
    input  enable, flash, ped_req,
    output light, ped_ack, phase
  );

endinterface

// File: rtl/phase_timer.sv
// Dwell counter for one lamp phase.
//   clock, reset : clock and synchronous active-high reset
//   en           : 0 holds the count
//   clear        : forces the count to 0 on the next enabled edge
//   term         : terminal value for the current phase
//   count        : current count (registered)
//   at_term_c    : combinational count == term
module phase_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             clear,
  input  logic [CNT_W-1:0] term,
  output logic [CNT_W-1:0] count,
  output logic             at_term_c
);

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (en) begin
      if (clear) count <= '0;
      else       count <= count + CNT_W'(1);
    end
  end

  assign at_term_c = (count == term);

endmodule

// File: rtl/traffic_lamp_ctrl.sv
// Single-head traffic lamp: RED -> GREEN -> YELLOW with programmable dwell,
// pedestrian-shortened GREEN and a flashing-yellow maintenance mode.
//   clock, reset : clock and synchronous active-high reset
//   bus (slave)  : enable/flash/ped_req in; light/ped_ack/phase out (registered)
module traffic_lamp_ctrl
  import lamp_pkg::*;
#(
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned RED_TICKS    = 4,
  parameter int unsigned GREEN_TICKS  = 6,
  parameter int unsigned YELLOW_TICKS = 2,
  parameter int unsigned MIN_GREEN    = 2,
  parameter int unsigned FLASH_TICKS  = 3
) (
  input  logic                clock,
  input  logic                reset,
  traffic_lamp_ctrl_if.slave  bus
);

  localparam longint unsigned CNT_LIM = longint'(1) << CNT_W;

  // Unsupported parameter sets are rejected at elaboration.
  if (RED_TICKS == 0 || GREEN_TICKS == 0 || YELLOW_TICKS == 0 ||
      FLASH_TICKS == 0 || MIN_GREEN == 0 || MIN_GREEN > GREEN_TICKS ||
      longint'(RED_TICKS) >= CNT_LIM || longint'(GREEN_TICKS) >= CNT_LIM ||
      longint'(YELLOW_TICKS) >= CNT_LIM || longint'(FLASH_TICKS) >= CNT_LIM) begin : g_bad_param
    $error("traffic_lamp_ctrl: invalid tick parameters");
  end

  localparam logic [CNT_W-1:0] RED_T    = CNT_W'(RED_TICKS - 1);
  localparam logic [CNT_W-1:0] GREEN_T  = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] YELLOW_T = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] FLASH_T  = CNT_W'(FLASH_TICKS - 1);
  localparam logic [CNT_W-1:0] MIN_G_T  = CNT_W'(MIN_GREEN - 1);

  state_t           state, state_d;
  logic [0:2]       light_q, light_d;
  logic             ack_q, ack_d;
  logic             pend_q, pend_d;
  logic             pend_set;
  logic             clr;
  logic [CNT_W-1:0] term;
  logic [CNT_W-1:0] cnt;
  logic             at_term;

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clock     (clock),
    .reset     (reset),
    .en        (bus.enable),
    .clear     (clr),
    .term      (term),
    .count     (cnt),
    .at_term_c (at_term)
  );

  // Terminal count for the phase being timed.
  always_comb begin
    term = RED_T;
    unique case (state)
      RED:    term = RED_T;
      GREEN:  term = GREEN_T;
      YELLOW: term = YELLOW_T;
      FLASH:  term = FLASH_T;
    endcase
  end

  // Next state, lamp, ack and pending request; priority !enable > flash > normal.
  always_comb begin
    state_d  = state;
    light_d  = light_q;
    ack_d    = 1'b0;
    pend_d   = pend_q;
    clr      = 1'b0;
    // A request on this very edge already counts toward shortening GREEN.
    pend_set = pend_q | bus.ped_req;
    if (bus.enable) begin
      if (bus.flash) begin
        // Pending request is frozen while maintenance flash is requested.
        if (state != FLASH) begin
          state_d = FLASH;
          clr     = 1'b1;
          light_d = RGY_YELLOW;
        end else if (at_term) begin
          clr     = 1'b1;
          light_d = (light_q == RGY_YELLOW) ? RGY_DARK : RGY_YELLOW;
        end
      end else begin
        pend_d = pend_set;
        unique case (state)
          RED: begin
            if (at_term) begin
              state_d = GREEN;
              clr     = 1'b1;
              light_d = RGY_GREEN;
            end
          end
          GREEN: begin
            if (pend_set ? (cnt >= MIN_G_T) : at_term) begin
              state_d = YELLOW;
              clr     = 1'b1;
              light_d = RGY_YELLOW;
            end
          end
          YELLOW: begin
            if (at_term) begin
              state_d = RED;
              clr     = 1'b1;
              light_d = RGY_RED;
              // Grant on RED entry; a same-edge request re-arms pending.
              if (pend_q) begin
                ack_d  = 1'b1;
                pend_d = bus.ped_req;
              end
            end
          end
          FLASH: begin
            state_d = RED;
            clr     = 1'b1;
            light_d = RGY_RED;
          end
        endcase
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= RED;
      light_q <= RGY_RED;
      ack_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state   <= state_d;
      light_q <= light_d;
      ack_q   <= ack_d;
      pend_q  <= pend_d;
    end
  end

  assign bus.light   = light_q;
  assign bus.ped_ack = ack_q;
  assign bus.phase   = state;

endmodule

// File: tb/tb_traffic_lamp_ctrl.sv
// Scoreboard bench for traffic_lamp_ctrl: a phase/elapsed-time reference
// model predicts light, ped_ack and phase for every clock; a monitor compares.
module tb_traffic_lamp_ctrl;

  localparam int RT = 4;
  localparam int GT = 6;
  localparam int YT = 2;
  localparam int MG = 2;
  localparam int FT = 3;

  typedef struct {
    logic [0:2] light;
    logic       ack;
    logic [1:0] phase;
    int         cyc;
  } exp_t;

  logic clock;
  logic reset;
  traffic_lamp_ctrl_if bus();

  traffic_lamp_ctrl #(
    .CNT_W(8), .RED_TICKS(RT), .GREEN_TICKS(GT), .YELLOW_TICKS(YT),
    .MIN_GREEN(MG), .FLASH_TICKS(FT)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // Reference model: phase (0=R,1=G,2=Y,3=flash), clocks already spent in it.
  int m_phase = 0;
  int m_el    = 0;
  bit m_pend  = 0;
  bit m_ack   = 0;

  function automatic logic [0:2] model_light();
    logic [0:2] l;
    case (m_phase)
      0:       l = 3'b100;
      1:       l = 3'b010;
      2:       l = 3'b001;
      default: l = (((m_el / FT) % 2) == 0) ? 3'b001 : 3'b000;
    endcase
    return l;
  endfunction

  task automatic model_step(input bit rst, input bit en, input bit fl, input bit req);
    bit want;
    int dwell;
    want  = m_pend || req;
    m_ack = 0;
    if (rst) begin
      m_phase = 0; m_el = 0; m_pend = 0;
    end else if (!en) begin
      // everything frozen
    end else if (fl) begin
      if (m_phase != 3) begin m_phase = 3; m_el = 0; end
      else m_el++;
    end else if (m_phase == 3) begin
      m_phase = 0; m_el = 0; m_pend = want;
    end else begin
      case (m_phase)
        0:       dwell = RT;
        1:       dwell = want ? MG : GT;
        default: dwell = YT;
      endcase
      if (m_el + 1 >= dwell) begin
        if (m_phase == 2) begin
          m_ack  = m_pend;
          m_pend = m_pend ? req : want;
        end else begin
          m_pend = want;
        end
        m_phase = (m_phase + 1) % 3;
        m_el    = 0;
      end else begin
        m_el++;
        m_pend = want;
      end
    end
  endtask

  // Apply one clock of stimulus and queue the response expected after the edge.
  task automatic drive(input bit rst, input bit en, input bit fl, input bit req);
    exp_t e;
    @(negedge clock);
    reset       = rst;
    bus.enable  = en;
    bus.flash   = fl;
    bus.ped_req = req;
    model_step(rst, en, fl, req);
    e.light = model_light();
    e.ack   = m_ack;
    e.phase = 2'(m_phase);
    e.cyc   = cyc;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 1, 0, 0);
  endtask

  // Advance with idle clocks until the model is at the given phase/elapsed point.
  task automatic run_to(input int p, input int el);
    bit found;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (m_phase == p && m_el == el) found = 1;
      else drive(0, 1, 0, 0);
    end
    if (!found && !(m_phase == p && m_el == el)) begin
      total++; bad++;
      $display("FAIL run_to timeout phase=%0d el=%0d want phase=%0d el=%0d", m_phase, m_el, p, el);
    end
  endtask

  // Monitor: the lamp presents an output every clock; compare just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      cyc++;
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        total++;
        if (bus.light !== e.light) begin
          bad++;
          $display("FAIL light cyc=%0d got=%b want=%b", e.cyc, bus.light, e.light);
        end
        total++;
        if (bus.ped_ack !== e.ack) begin
          bad++;
          $display("FAIL ped_ack cyc=%0d got=%b want=%b", e.cyc, bus.ped_ack, e.ack);
        end
        total++;
        if (bus.phase !== e.phase) begin
          bad++;
          $display("FAIL phase cyc=%0d got=%0d want=%0d", e.cyc, bus.phase, e.phase);
        end
      end
    end
  end

  initial begin
    bit fl;
    reset       = 1'b1;
    bus.enable  = 1'b0;
    bus.flash   = 1'b0;
    bus.ped_req = 1'b0;

    // Reset, then three plain 12-clock cycles.
    for (int i = 0; i < 3; i++) drive(1, 1, 0, 0);
    idle(36);

    // Request on first GREEN clock.
    run_to(1, 0);
    drive(0, 1, 0, 1);
    idle(14);

    // Request on fifth GREEN clock, then one during RED.
    run_to(1, 4);
    drive(0, 1, 0, 1);
    run_to(0, 1);
    drive(0, 1, 0, 1);
    idle(24);

    // Flash asserted mid-GREEN for 14 clocks.
    run_to(1, 2);
    for (int i = 0; i < 14; i++) drive(0, 1, 1, 0);
    idle(14);

    // Freeze mid-YELLOW; requests and flash ignored meanwhile.
    run_to(2, 0);
    for (int i = 0; i < 5; i++) drive(0, 0, i[0], 1);
    idle(24);

    // Reset on the same edge as flash and a request, with a request pending.
    run_to(0, 1);
    drive(0, 1, 0, 1);
    drive(1, 1, 1, 1);
    idle(24);

    // Randomized traffic.
    fl = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99) < 3) fl = ~fl;
      drive($urandom_range(199) == 0, $urandom_range(9) != 0, fl, $urandom_range(9) == 0);
    end
    idle(4);

    @(negedge clock);
    @(negedge clock);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/traffic_lamp_ctrl.md
Name: traffic_lamp_ctrl

Overview:
Parametrised successor to the fixed three-phase cyclic lamp. It sequences RED -> GREEN -> YELLOW with a programmable dwell time per phase, a pedestrian request that shortens GREEN, and a flashing-yellow maintenance mode. The block is a single-clock Moore FSM driving one lamp head with registered outputs. It sits directly under a junction-level controller or testbench.

Parameters:
CNT_W, 8, width of the dwell counter; every *_TICKS value must be < 2**CNT_W
RED_TICKS, 4, clocks spent in RED (>=1)
GREEN_TICKS, 6, clocks spent in GREEN with no pedestrian request (>=1)
YELLOW_TICKS, 2, clocks spent in YELLOW (>=1)
MIN_GREEN, 2, minimum GREEN clocks when a pedestrian request is pending (1..GREEN_TICKS)
FLASH_TICKS, 3, half-period of the yellow blink in FLASH mode (>=1)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  1 = advance normally; 0 = freeze state, counter and outputs
flash  input  1  level; 1 = enter and stay in FLASH mode
ped_req  input  1  pedestrian request, sampled every clock; a 1-cycle pulse is sufficient
light  output  3  [0:2] = R,G,Y one-hot: RED=100, GREEN=010, YELLOW=001, dark=000
ped_ack  output  1  1-cycle pulse granting the pedestrian walk
phase  output  2  current state encoding, for debug

Behaviour:
- Clock and reset: one clock, `clock`; reset `reset` is synchronous and active-high. Reset has priority over all other inputs.
- On reset: state=RED, counter=0, light=100, ped_ack=0, ped_pending=0, phase=RED.
- States and encoding: RED=0, GREEN=1, YELLOW=2, FLASH=3. Outputs are registered and change in the same edge as the state. There is no extra latency.
- Dwell counter: counts 0..T-1 within a phase and resets to 0 on every state change. The transition fires on the edge where counter==T-1, so each phase is visible for exactly T clocks.
- Normal sequence: RED(RED_TICKS) -> GREEN -> YELLOW(YELLOW_TICKS) -> RED. With the defaults the period is 12 clocks.
- Pedestrian handling:
  - ped_req=1 on any enabled clock sets ped_pending.
  - In GREEN with ped_pending=1, the exit condition is counter >= MIN_GREEN-1, checked in place of counter==GREEN_TICKS-1.
  - A request arriving after that point in GREEN exits at the next edge.
  - On the edge that enters RED from YELLOW: if ped_pending=1, ped_ack=1 for that one cycle and ped_pending clears.
  - If ped_req=1 on that same edge, set wins and ped_pending stays 1. ped_ack is still issued.
  - A request made during RED or YELLOW is held. It shortens the next GREEN and is acked on the following RED entry.
- FLASH mode:
  - flash=1 (and not reset) moves to FLASH on the next edge from any state, mid-phase included. The counter goes to 0.
  - In FLASH, light alternates 001 / 000, toggling every FLASH_TICKS clocks, starting at 001.
  - ped_pending is held and ped_ack stays 0.
  - flash=0 returns to RED with counter=0 on the next edge. light=100.
- enable=0: state, counter, ped_pending and light all hold, and ped_ack=0. ped_req is ignored. flash is also ignored; enable gates everything except reset.
- Priority each edge: reset > !enable > flash > normal/pedestrian logic.
- Counter width: values compare at CNT_W bits. There is no wrap, because the counter never exceeds max(*_TICKS)-1.
- Invalid parameters (any *_TICKS == 0, MIN_GREEN > GREEN_TICKS) are flagged by an elaboration-time check. They are not supported.

Decomposition:
- Shared package `lamp_pkg`:
  - state encodings RED/GREEN/YELLOW/FLASH (2-bit)
  - lamp codes RGY_RED=100, RGY_GREEN=010, RGY_YELLOW=001, RGY_DARK=000
- One sub-module, `phase_timer`: a CNT_W-bit counter with clear, hold (enable) and a terminal-compare input. The FSM drives the terminal count per state.

Test Plan:
- Reset held 3 clocks, then released with enable=1 and no requests -> light=100 for 4 clocks, 010 for 6, 001 for 2, repeating every 12 clocks; ped_ack never asserts.
- ped_req pulse on the first GREEN clock -> GREEN lasts exactly 2 clocks, YELLOW lasts 2 clocks, ped_ack=1 on the single clock where light first returns to 100.
- ped_req pulse on the 5th GREEN clock (counter=4) -> YELLOW on the next edge (GREEN lasts 5 clocks); ped_req during RED -> next GREEN is 2 clocks and ped_ack occurs at the following RED entry.
- flash=1 asserted mid-GREEN for 14 clocks -> the next edge shows 001, then the pattern 001x3, 000x3, ... Deasserting flash -> the next edge shows 100, with a full 4-clock RED.
- enable=0 for 5 clocks mid-YELLOW -> light frozen at 001 and the remaining YELLOW count resumes unchanged afterwards; ped_req during the freeze is not recorded.
- reset asserted on the same edge as flash=1 and ped_req=1 -> light=100, ped_ack=0, and the pending request is cleared (the next GREEN is the full 6 clocks).
